// File: rtl/layer_pkg.sv
// Shared types for the feature-map streaming path: pixel words, channel vectors, TX FSM states.
package layer_pkg;

  localparam int unsigned FM_DEPTH = 64;
  localparam int unsigned PIX_W    = 16;

  typedef logic [PIX_W-1:0] pixel_t;
  typedef pixel_t fm_vec_t [FM_DEPTH];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty/count flags and a combinational head read.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head_c,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count_nxt;
  logic             do_push, do_pop;

  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign count_nxt = count + CNT_W'(do_push) - CNT_W'(do_pop);
  assign head_c    = mem[rd_ptr];

  // Storage is not reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
      full  <= (count_nxt == CNT_W'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/fm_stream_tx.sv
// Feature-map stream transmitter: buffers upstream pixels and replays one frame in raster
// order with verticle_sync framing and a minimum spacing between data_out_valid strobes.
module fm_stream_tx
  import layer_pkg::*;
#(
  parameter int unsigned FM_WIDTH   = 56,
  parameter int unsigned FM_HEIGHT  = 56,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PIX_GAP    = 2,
  localparam int unsigned COL_W = (FM_WIDTH > 1) ? $clog2(FM_WIDTH) : 1,
  localparam int unsigned ROW_W = (FM_HEIGHT > 1) ? $clog2(FM_HEIGHT) : 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  fm_vec_t          in_data,
  output logic             verticle_sync,
  output logic             data_out_valid,
  output fm_vec_t          data_out,
  output logic             busy,
  output logic             frame_done,
  output logic [COL_W-1:0] col_idx,
  output logic [ROW_W-1:0] row_idx
);

  localparam int unsigned DATA_W    = FM_DEPTH * PIX_W;
  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned FRAME_PIX = FM_WIDTH * FM_HEIGHT;
  localparam int unsigned IN_W      = $clog2(FRAME_PIX + 1);
  localparam int unsigned GAP_W     = (PIX_GAP > 1) ? $clog2(PIX_GAP) : 1;

  tx_state_e         state, next_state;
  logic [GAP_W-1:0]  gap_cnt;
  logic [IN_W-1:0]   in_cnt, in_cnt_nxt;
  logic [DATA_W-1:0] fifo_wdata, fifo_head_c;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full, fifo_empty, full_nxt;
  logic              push, emit, last_pix;
  logic              vs_d, busy_d, done_d, ready_d;

  assign push     = in_valid && in_ready;
  assign emit     = (state == RUN) && !fifo_empty && (gap_cnt == '0);
  assign last_pix = (col_idx == COL_W'(FM_WIDTH - 1)) && (row_idx == ROW_W'(FM_HEIGHT - 1));

  always_comb begin
    for (int i = 0; i < FM_DEPTH; i++) fifo_wdata[i*PIX_W +: PIX_W] = in_data[i];
  end

  sync_fifo #(
    .WIDTH(DATA_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .pop   (emit),
    .wdata (fifo_wdata),
    .head_c(fifo_head_c),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= next_state;
  end

  // Outputs are decoded from the state being entered so they line up with it;
  // frame_done/verticle_sync rise on the exit from DONE, one cycle after the last strobe.
  always_comb begin
    next_state = state;
    vs_d       = 1'b1;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    ready_d    = 1'b0;
    in_cnt_nxt = in_cnt + IN_W'(push);
    full_nxt   = fifo_full ? !emit
                           : ((fifo_count == CNT_W'(FIFO_DEPTH - 1)) && push && !emit);
    case (state)
      IDLE:    if (start) next_state = ARM;
      ARM:     next_state = RUN;
      RUN:     if (emit && last_pix) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    vs_d    = (next_state == IDLE);
    busy_d  = (next_state != IDLE);
    done_d  = (state == DONE);
    ready_d = ((next_state == ARM) || (next_state == RUN)) && !full_nxt
              && (in_cnt_nxt != IN_W'(FRAME_PIX));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      verticle_sync  <= 1'b1;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
      in_ready       <= 1'b0;
      data_out_valid <= 1'b0;
      gap_cnt        <= '0;
      in_cnt         <= '0;
      col_idx        <= '0;
      row_idx        <= '0;
      for (int i = 0; i < FM_DEPTH; i++) data_out[i] <= '0;
    end else begin
      verticle_sync  <= vs_d;
      busy           <= busy_d;
      frame_done     <= done_d;
      in_ready       <= ready_d;
      data_out_valid <= emit;
      in_cnt         <= (next_state == ARM) ? '0 : in_cnt_nxt;
      if (emit) begin
        gap_cnt <= GAP_W'(PIX_GAP - 1);
        for (int i = 0; i < FM_DEPTH; i++) data_out[i] <= fifo_head_c[i*PIX_W +: PIX_W];
        // Raster advance; both counters wrap to zero on the frame's last pixel.
        if (col_idx == COL_W'(FM_WIDTH - 1)) begin
          col_idx <= '0;
          row_idx <= (row_idx == ROW_W'(FM_HEIGHT - 1)) ? '0 : row_idx + ROW_W'(1);
        end else begin
          col_idx <= col_idx + COL_W'(1);
        end
      end else if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - GAP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fm_stream_tx.sv
// Directed bench for fm_stream_tx on a 4x2 frame: cycle tables for a full frame and FIFO-full
// pacing, plus sequences for backpressure, ignored start, and mid-frame reset.
module tb_fm_stream_tx;
  import layer_pkg::*;

  localparam int unsigned W  = 4;
  localparam int unsigned H  = 2;
  localparam int unsigned FD = 4;

  typedef struct {
    logic start;
    int   idx;   // expected strobe pixel index, -1 = no strobe
    logic vs;
    logic busy;
    logic done;
    logic rdy;
  } vec_t;

  logic clk = 1'b0;
  logic rstn;
  logic start_a, in_valid_a, start_b, in_valid_b;
  fm_vec_t in_data_a, in_data_b, data_out_a, data_out_b;
  logic in_ready_a, vs_a, valid_a, busy_a, done_a;
  logic in_ready_b, vs_b, valid_b, busy_b, done_b;
  logic [1:0] col_a, col_b;
  logic       row_a, row_b;

  int total = 0;
  int bad   = 0;
  int src_a = 0, src_b = 0, base_a = 0;

  vec_t tbl_a [19];
  vec_t tbl_b [12];

  always #5 clk = ~clk;

  fm_stream_tx #(.FM_WIDTH(W), .FM_HEIGHT(H), .FIFO_DEPTH(FD), .PIX_GAP(2)) dut_a (
    .clk(clk), .rstn(rstn), .start(start_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_data(in_data_a), .verticle_sync(vs_a), .data_out_valid(valid_a), .data_out(data_out_a),
    .busy(busy_a), .frame_done(done_a), .col_idx(col_a), .row_idx(row_a)
  );

  fm_stream_tx #(.FM_WIDTH(W), .FM_HEIGHT(H), .FIFO_DEPTH(FD), .PIX_GAP(8)) dut_b (
    .clk(clk), .rstn(rstn), .start(start_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data_b), .verticle_sync(vs_b), .data_out_valid(valid_b), .data_out(data_out_b),
    .busy(busy_b), .frame_done(done_b), .col_idx(col_b), .row_idx(row_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_data();
    for (int c = 0; c < FM_DEPTH; c++) begin
      in_data_a[c] = 16'((base_a + src_a) * 256 + c);
      in_data_b[c] = 16'(src_b * 256 + c);
    end
  endtask

  // One clock: handshakes seen before the edge advance the upstream pixel indices.
  task automatic tick();
    logic acc_a, acc_b;
    acc_a = in_valid_a && in_ready_a;
    acc_b = in_valid_b && in_ready_b;
    @(posedge clk);
    #1;
    if (acc_a) src_a++;
    if (acc_b) src_b++;
    drive_data();
  endtask

  task automatic check_row(input string tag, input vec_t v, input logic vld, input logic vs,
                           input logic bsy, input logic dn, input logic rdy, input pixel_t d0,
                           input pixel_t d63, input int col, input int row, input int base);
    chk({tag, "_valid"}, int'(vld), (v.idx >= 0) ? 1 : 0);
    chk({tag, "_vs"},    int'(vs),  int'(v.vs));
    chk({tag, "_busy"},  int'(bsy), int'(v.busy));
    chk({tag, "_done"},  int'(dn),  int'(v.done));
    chk({tag, "_ready"}, int'(rdy), int'(v.rdy));
    if (v.idx >= 0) begin
      chk({tag, "_d0"},  int'(d0),  (base + v.idx) * 256);
      chk({tag, "_d63"}, int'(d63), (base + v.idx) * 256 + 63);
      chk({tag, "_col"}, col, (v.idx + 1) % W);
      chk({tag, "_row"}, row, ((v.idx + 1) / W) % H);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_vs"},    int'(vs_a), 1);
    chk({tag, "_valid"}, int'(valid_a), 0);
    chk({tag, "_busy"},  int'(busy_a), 0);
    chk({tag, "_done"},  int'(done_a), 0);
    chk({tag, "_ready"}, int'(in_ready_a), 0);
    chk({tag, "_col"},   int'(col_a), 0);
    chk({tag, "_row"},   int'(row_a), 0);
    chk({tag, "_dout"},  int'(data_out_a[0]), 0);
  endtask

  initial begin
    int n, last, stall_at, seen_done, first_col, first_row;

    // Full frame, PIX_GAP=2, upstream always valid.
    tbl_a[0]  = '{1'b1, -1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl_a[1]  = '{1'b0, -1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl_a[2]  = '{1'b0,  0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl_a[3]  = '{1'b0, -1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl_a[4]  = '{1'b0,  1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl_a[5]  = '{1'b0, -1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl_a[6]  = '{1'b0,  2, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl_a[7]  = '{1'b0, -1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl_a[8]  = '{1'b0,  3, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl_a[9]  = '{1'b0, -1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl_a[10] = '{1'b0,  4, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl_a[11] = '{1'b0, -1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl_a[12] = '{1'b0,  5, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl_a[13] = '{1'b0, -1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl_a[14] = '{1'b0,  6, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl_a[15] = '{1'b0, -1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl_a[16] = '{1'b0,  7, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl_a[17] = '{1'b0, -1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl_a[18] = '{1'b0, -1, 1'b1, 1'b0, 1'b0, 1'b0};
    // FIFO fill with PIX_GAP=8: ready drops at 4 entries, returns the cycle after a pop.
    tbl_b[0]  = '{1'b1, -1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl_b[1]  = '{1'b0, -1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl_b[2]  = '{1'b0,  0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl_b[3]  = '{1'b0, -1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl_b[4]  = '{1'b0, -1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int k = 5; k < 10; k++) tbl_b[k] = '{1'b0, -1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl_b[10] = '{1'b0,  1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl_b[11] = '{1'b0, -1, 1'b0, 1'b1, 1'b0, 1'b0};

    rstn = 1'b0; start_a = 1'b0; in_valid_a = 1'b0; start_b = 1'b0; in_valid_b = 1'b0;
    drive_data();
    repeat ($urandom_range(2, 5)) tick();
    check_reset_vals("rst");
    rstn = 1'b1;
    tick();

    // Full frame on dut_a.
    in_valid_a = 1'b1;
    for (int k = 0; k < 19; k++) begin
      start_a = tbl_a[k].start;
      tick();
      check_row($sformatf("frame_k%0d", k), tbl_a[k], valid_a, vs_a, busy_a, done_a, in_ready_a,
                data_out_a[0], data_out_a[63], int'(col_a), int'(row_a), 0);
    end
    start_a = 1'b0;
    chk("frame_pushed", src_a, 8);

    // Upstream valid while idle is not taken.
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("idle_ready", int'(in_ready_a), 0);
      chk("idle_valid", int'(valid_a), 0);
    end
    chk("idle_pushed", src_a, 8);
    in_valid_a = 1'b0;

    // FIFO full on dut_b.
    in_valid_b = 1'b1;
    for (int k = 0; k < 12; k++) begin
      start_b = tbl_b[k].start;
      tick();
      check_row($sformatf("full_k%0d", k), tbl_b[k], valid_b, vs_b, busy_b, done_b, in_ready_b,
                data_out_b[0], data_out_b[63], int'(col_b), int'(row_b), 0);
    end
    start_b = 1'b0;
    in_valid_b = 1'b0;
    chk("full_pushed", src_b, 6);

    // Backpressure: stall after 5 pixels for 20 cycles; start pulsed mid-frame.
    src_a = 0; base_a = 20; drive_data();
    start_a = 1'b1; in_valid_a = 1'b1;
    n = 0; last = -100; stall_at = -1; seen_done = 0;
    for (int c = 0; c < 150 && seen_done == 0; c++) begin
      tick();
      start_a = 1'b0;
      if (valid_a) begin
        chk("bp_order", int'(data_out_a[0]), (20 + n) * 256);
        chk("bp_gap", (c - last >= 2) ? 1 : 0, 1);
        chk("bp_after_push", (n < src_a) ? 1 : 0, 1);
        last = c;
        n++;
      end
      if (done_a) seen_done = 1;
      if (src_a == 5 && stall_at < 0) stall_at = c;
      in_valid_a = !(stall_at >= 0 && c < stall_at + 20);
      if (stall_at >= 0 && c == stall_at + 12) start_a = 1'b1;
      if (stall_at >= 0 && c == stall_at + 13) begin
        chk("bp_start_col", int'(col_a), 1);
        chk("bp_start_row", int'(row_a), 1);
        chk("bp_start_busy", int'(busy_a), 1);
      end
    end
    chk("bp_count", n, 8);
    chk("bp_done", seen_done, 1);
    in_valid_a = 1'b0;
    tick();
    chk("bp_idle_vs", int'(vs_a), 1);
    chk("bp_idle_busy", int'(busy_a), 0);

    // Reset during pixel 3, then a clean new frame.
    src_a = 0; base_a = 40; drive_data();
    start_a = 1'b1; in_valid_a = 1'b1; n = 0;
    for (int c = 0; c < 40 && n < 3; c++) begin
      tick();
      start_a = 1'b0;
      if (valid_a) n++;
    end
    chk("abort_reach", n, 3);
    repeat ($urandom_range(0, 1)) tick();
    #2 rstn = 1'b0;
    #1 check_reset_vals("abort_rst");
    tick();
    tick();
    rstn = 1'b1;
    src_a = 0; base_a = 60; drive_data();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("abort_no_done", int'(done_a), 0);
      chk("abort_no_valid", int'(valid_a), 0);
    end
    start_a = 1'b1;
    n = 0; seen_done = 0; first_col = -1; first_row = -1;
    for (int c = 0; c < 60 && seen_done == 0; c++) begin
      tick();
      start_a = 1'b0;
      if (valid_a) begin
        chk("new_order", int'(data_out_a[0]), (60 + n) * 256);
        if (n == 0) begin
          first_col = int'(col_a);
          first_row = int'(row_a);
        end
        n++;
      end
      if (done_a) seen_done = 1;
    end
    chk("new_first_col", first_col, 1);
    chk("new_first_row", first_row, 0);
    chk("new_count", n, 8);
    chk("new_done", seen_done, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
